dct8_block_sequencer: RTL and testbench

- Sequencer for the 8-point 1D DCT datapath.
- Accepts samples serially over a valid/ready stream and packs 8 of them into a parallel vector.
- Pulses a start strobe to the datapath, waits a fixed latency, then captures the 8 coefficients and streams them out serially with backpressure.
- Sits between the sample source (row/column feeder) and the combinational/pipelined dct1d datapath.

---
 rtl/dct_pkg.sv | 15 +
 rtl/dct_sipo_buf.sv | 29 ++
 rtl/dct8_block_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dct8_block_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, FSM state type and lane helper for the 8-point DCT sequencer
//   DCT_PTS/DCT_IDX_W : block size and lane index width
//   LAT_MIN/LAT_MAX   : legal range of the datapath latency parameter
//   dct_state_t       : LOAD, ISSUE, WAIT, DRAIN
//   lane_lsb()        : bit offset of lane k in a packed vector of w-bit lanes
package dct_pkg;
   localparam int DCT_PTS   = 8;
   localparam int DCT_IDX_W = 3;
   localparam int LAT_MIN   = 1;
   localparam int LAT_MAX   = 15;
   typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} dct_state_t;
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/dct_sipo_buf.sv
// dct_sipo_buf: 8-lane serial-in/parallel-out sample buffer
//   clk, reset : clock, asynchronous active-high reset (clears all lanes)
//   we_i       : write din_i into lane idx_i
//   clr_i      : zero all lanes (a simultaneous write still lands)
//   idx_i      : lane index 0..7
//   din_i      : N-bit sample
//   lanes_o    : packed lanes, lane k = bits [k*N +: N]
module dct_sipo_buf
   import dct_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we_i,
   input  logic                   clr_i,
   input  logic [DCT_IDX_W-1:0]   idx_i,
   input  logic [N-1:0]           din_i,
   output logic [DCT_PTS*N-1:0]   lanes_o
);
   logic [DCT_PTS*N-1:0] lanes_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) lanes_q <= '0;
      else begin
         if (clr_i) lanes_q <= '0;
         if (we_i) lanes_q[lane_lsb(int'(idx_i), N) +: N] <= din_i;
      end
   assign lanes_o = lanes_q;
endmodule

// File: rtl/dct8_block_sequencer.sv
// dct8_block_sequencer: packs 8 serial samples, launches the DCT datapath, streams the 8 coefficients out
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : sample stream handshake, in_data = signed N-bit sample
//   dct_x, dct_start     : packed block to the datapath and its one-cycle launch strobe
//   dct_X                : packed coefficients, valid LAT cycles after dct_start
//   out_valid/out_ready  : coefficient stream handshake, out_data = X[out_idx]
//   busy                 : low only when idle in LOAD with no samples held
//   Optional macro DCT_SEQ_PINGPONG_EN adds a shadow input buffer that fills while a block drains.
module dct8_block_sequencer
   import dct_pkg::*;
#(
   parameter int N   = 16,
   parameter int LAT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_data,
   output logic [DCT_PTS*N-1:0]   dct_x,
   output logic                   dct_start,
   input  logic [DCT_PTS*N-1:0]   dct_X,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           out_data,
   output logic [DCT_IDX_W-1:0]   out_idx,
   output logic                   busy
);
   // WAIT lasts LAT cycles, so the counter starts at LAT-1; out-of-range LAT is clamped
   localparam logic [3:0] WAIT_INIT = 4'((LAT < LAT_MIN) ? 0 : (LAT > LAT_MAX) ? LAT_MAX - 1 : LAT - 1);
   localparam logic [DCT_IDX_W-1:0] LAST = DCT_IDX_W'(DCT_PTS - 1);
   dct_state_t state_q, state_d;
   logic [DCT_IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
   logic [3:0] wait_q, wait_d;
   logic [DCT_PTS*N-1:0] obuf_q, obuf_d;
   logic [N-1:0] out_data_q, out_data_d;
   logic in_ready_q, in_ready_d, dct_start_q, out_valid_q, busy_q;
   logic in_xfer, out_xfer, last_out, load_we;
   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;
   assign last_out = out_xfer && idx_q == LAST;
   assign load_we  = in_xfer && state_q == LOAD;
`ifdef DCT_SEQ_PINGPONG_EN
   localparam int SH_W = DCT_IDX_W + 1;
   localparam logic [SH_W-1:0] FULL = SH_W'(DCT_PTS);
   // bank_q selects the active (datapath-facing) buffer; the other one is the shadow
   logic bank_q, bank_d, sh_we;
   logic [SH_W-1:0] sh_cnt_q, sh_cnt_d;
   logic [DCT_PTS*N-1:0] lanes0, lanes1;
   assign sh_we = in_xfer && (state_q == WAIT || state_q == DRAIN);
   dct_sipo_buf #(.N(N)) u_buf0 (
      .clk     (clk),
      .reset   (reset),
      .we_i    (bank_q ? sh_we : load_we),
      .clr_i   (last_out && !bank_q),
      .idx_i   (bank_q ? sh_cnt_q[DCT_IDX_W-1:0] : cnt_q),
      .din_i   (in_data),
      .lanes_o (lanes0)
   );
   dct_sipo_buf #(.N(N)) u_buf1 (
      .clk     (clk),
      .reset   (reset),
      .we_i    (bank_q ? load_we : sh_we),
      .clr_i   (last_out && bank_q),
      .idx_i   (bank_q ? cnt_q : sh_cnt_q[DCT_IDX_W-1:0]),
      .din_i   (in_data),
      .lanes_o (lanes1)
   );
   assign dct_x      = bank_q ? lanes1 : lanes0;
   assign in_ready_d = state_d == LOAD || ((state_d == WAIT || state_d == DRAIN) && sh_cnt_d != FULL);
`else
   dct_sipo_buf #(.N(N)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .we_i    (load_we),
      .clr_i   (last_out),
      .idx_i   (cnt_q),
      .din_i   (in_data),
      .lanes_o (dct_x)
   );
   assign in_ready_d = state_d == LOAD;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      idx_d   = idx_q;
      obuf_d  = obuf_q;
`ifdef DCT_SEQ_PINGPONG_EN
      bank_d   = bank_q;
      sh_cnt_d = sh_cnt_q + SH_W'(sh_we);
`endif
      case (state_q)
         LOAD:
            if (in_xfer) begin
               cnt_d = cnt_q + DCT_IDX_W'(1);
               if (cnt_q == LAST) state_d = ISSUE;
            end
         ISSUE: begin
            state_d = WAIT;
            wait_d  = WAIT_INIT;
         end
         WAIT:
            if (wait_q == 4'd0) begin
               state_d = DRAIN;
               obuf_d  = dct_X;
               idx_d   = '0;
            end else wait_d = wait_q - 4'd1;
         DRAIN:
            if (out_xfer) begin
               idx_d = idx_q + DCT_IDX_W'(1);
               if (idx_q == LAST) begin
`ifdef DCT_SEQ_PINGPONG_EN
                  // swap banks; a full shadow launches at once, a partial one resumes loading
                  bank_d   = !bank_q;
                  state_d  = sh_cnt_d == FULL ? ISSUE : LOAD;
                  cnt_d    = sh_cnt_d[DCT_IDX_W-1:0];
                  sh_cnt_d = '0;
`else
                  state_d = LOAD;
`endif
               end
            end
      endcase
   end
   assign out_data_d = obuf_d[lane_lsb(int'(idx_d), N) +: N];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         wait_q      <= '0;
         idx_q       <= '0;
         obuf_q      <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         dct_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef DCT_SEQ_PINGPONG_EN
         bank_q      <= 1'b0;
         sh_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         idx_q       <= idx_d;
         obuf_q      <= obuf_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         dct_start_q <= state_d == ISSUE;
         out_valid_q <= state_d == DRAIN;
         busy_q      <= !(state_d == LOAD && cnt_d == '0);
`ifdef DCT_SEQ_PINGPONG_EN
         bank_q      <= bank_d;
         sh_cnt_q    <= sh_cnt_d;
`endif
      end
   assign in_ready  = in_ready_q;
   assign dct_start = dct_start_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = idx_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_dct8_block_sequencer.sv
// tb_dct8_block_sequencer: bench for dct8_block_sequencer with a X_k=2*x_k datapath stub of latency LAT
module tb_dct8_block_sequencer;
   localparam int N   = 16;
   localparam int LAT = 2;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, dct_start, out_valid, busy;
   logic [N-1:0] in_data = '0, out_data;
   logic [8*N-1:0] dct_x, dct_X;
   logic [8*N-1:0] blk = '0;
   logic [15:0] hist = '0;
   logic [2:0] out_idx;
   int total = 0, bad = 0;
   typedef struct { logic [N-1:0] x; logic [N-1:0] y; } vec_t;
   vec_t tbl [24];

   dct8_block_sequencer #(.N(N), .LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dct_x     (dct_x),
      .dct_start (dct_start),
      .dct_X     (dct_X),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [8*N-1:0] dbl(input logic [8*N-1:0] v);
      logic [8*N-1:0] r;
      for (int k = 0; k < 8; k++) r[k*N +: N] = v[k*N +: N] << 1;
      return r;
   endfunction

   // datapath stub: coefficients are correct only in the cycle exactly LAT after dct_start
   always @(posedge clk) begin
      hist <= {hist[14:0], dct_start};
      if (dct_start) blk <= dct_x;
   end
   assign dct_X = hist[LAT-1] ? dbl(blk) : ~dbl(blk);

   task automatic chk(input string name, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 128'(act), 128'(exp));
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      repeat (2) step;
      chk1("rst_held_in_ready", in_ready, 1'b0);
      chk1("rst_held_out_valid", out_valid, 1'b0);
      chk1("rst_start", dct_start, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_dct_x", dct_x, '0);
      chk("rst_out_data", 128'(out_data), '0);
      chk("rst_out_idx", 128'(out_idx), '0);
      reset = 1'b0;
      step;
      chk1("post_rst_in_ready", in_ready, 1'b1);
   endtask

   task automatic run_block(input int b, input bit gaps, input int hold_at, input int rst_at);
      logic [8*N-1:0] exp_x;
      logic [4:0] pat;
      int k, g, ir_bad;
      bit xf;
      pat = 5'b01101;
      exp_x = '0;
      k = 0;
      g = 0;
      ir_bad = 0;
      out_ready = 1'b1;
      while (k < 8 && g < 100) begin
         in_valid = gaps ? pat[g % 5] : 1'b1;
         in_data = in_valid ? tbl[b*8+k].x : 16'hBAD0;
         xf = in_valid && in_ready;
         exp_x[k*N +: N] = tbl[b*8+k].x;
         step;
         if (xf) k++;
         g++;
      end
      chk("load_count", 128'(k), 128'(8));
`ifdef DCT_SEQ_PINGPONG_EN
      in_valid = 1'b0;
`else
      in_valid = 1'b1;
`endif
      in_data = 16'hDEAD;
      chk1("start_after_8th", dct_start, 1'b1);
      chk("dct_x_lanes", dct_x, exp_x);
      step;
      chk1("start_one_cycle", dct_start, 1'b0);
      g = 0;
      while (!out_valid && g < 50) begin
         if (in_ready) ir_bad++;
         step;
         g++;
      end
      for (int j = 0; j < 8; j++) begin
         if (in_ready) ir_bad++;
         chk1("out_valid", out_valid, 1'b1);
         chk("out_idx", 128'(out_idx), 128'(j));
         chk("out_data", 128'(out_data), 128'(tbl[b*8+j].y));
         if (j == hold_at) begin
            out_ready = 1'b0;
            repeat (3) begin
               step;
               chk1("hold_valid", out_valid, 1'b1);
               chk("hold_idx", 128'(out_idx), 128'(j));
               chk("hold_data", 128'(out_data), 128'(tbl[b*8+j].y));
            end
            out_ready = 1'b1;
         end
         step;
         if (j == rst_at) begin
            in_valid = 1'b0;
            do_reset;
            return;
         end
      end
      in_valid = 1'b0;
`ifndef DCT_SEQ_PINGPONG_EN
      chk("in_ready_blocked", 128'(ir_bad), '0);
`endif
      chk1("out_valid_drop", out_valid, 1'b0);
      chk1("busy_idle", busy, 1'b0);
      chk1("in_ready_back", in_ready, 1'b1);
   endtask

   task automatic random_test;
      logic [N-1:0] smp [$];
      logic [8*N-1:0] ex;
      int acc, outs, iss, pend;
      logic exp_rdy;
      acc = 0;
      outs = 0;
      iss = 0;
      do_reset;
      for (int c = 0; c < 1500; c++) begin
         pend = acc - 8 * (outs / 8);
`ifdef DCT_SEQ_PINGPONG_EN
         exp_rdy = !dct_start && pend < 16;
`else
         exp_rdy = pend < 8;
`endif
         chk1("rnd_in_ready", in_ready, exp_rdy);
         chk1("rnd_busy", busy, pend != 0);
         if (dct_start) begin
            for (int k = 0; k < 8; k++) ex[k*N +: N] = smp[iss*8+k];
            chk("rnd_dct_x", dct_x, ex);
            iss++;
         end
         if (out_valid) begin
            chk("rnd_out_data", 128'(out_data), 128'(16'(smp[outs] << 1)));
            chk("rnd_out_idx", 128'(out_idx), 128'(outs % 8));
         end
         in_valid = c < 1200 ? ($urandom_range(0, 3) != 0) : 1'b0;
         in_data = 16'($urandom);
         out_ready = c < 1200 ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (in_valid && in_ready) begin
            smp.push_back(in_data);
            acc++;
         end
         if (out_valid && out_ready) outs++;
         step;
      end
      in_valid = 1'b0;
      chk("rnd_all_drained", 128'(outs), 128'(8 * (acc / 8)));
      chk1("rnd_some_blocks", outs >= 64, 1'b1);
   endtask

`ifdef DCT_SEQ_PINGPONG_EN
   task automatic pingpong_test;
      int sent, outs, starts, t_last7, t_start2;
      sent = 0;
      outs = 0;
      starts = 0;
      t_last7 = -1;
      t_start2 = -2;
      do_reset;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && outs < 16; c++) begin
         if (dct_start) begin
            starts++;
            if (starts == 2) t_start2 = c;
         end
         if (out_valid) chk("pp_out_data", 128'(out_data), 128'(16'(2 * (100 + outs))));
         in_valid = sent < 16;
         in_data = 16'(100 + sent);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            if (outs == 7) t_last7 = c;
            outs++;
         end
         step;
      end
      in_valid = 1'b0;
      chk("pp_second_start", 128'(t_start2), 128'(t_last7 + 1));
      chk("pp_sent", 128'(sent), 128'(16));
      chk("pp_outs", 128'(outs), 128'(16));
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 8; k++) begin
         tbl[k]   = '{x: 16'(k + 1),  y: 16'(2 * (k + 1))};
         tbl[8+k] = '{x: 16'(k + 10), y: 16'(2 * (k + 10))};
      end
      tbl[16] = '{x: 16'h8000, y: 16'h0000};
      tbl[17] = '{x: 16'h7FFF, y: 16'hFFFE};
      tbl[18] = '{x: 16'hFFFF, y: 16'hFFFE};
      tbl[19] = '{x: 16'h0000, y: 16'h0000};
      tbl[20] = '{x: 16'h4000, y: 16'h8000};
      tbl[21] = '{x: 16'hC001, y: 16'h8002};
      tbl[22] = '{x: 16'h0001, y: 16'h0002};
      tbl[23] = '{x: 16'hABCD, y: 16'h579A};
      do_reset;
      run_block(0, 1'b0, 3, -1);
      run_block(2, 1'b1, -1, -1);
      run_block(0, 1'b0, -1, 5);
      run_block(1, 1'b0, -1, -1);
      random_test;
`ifdef DCT_SEQ_PINGPONG_EN
      pingpong_test;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
